// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scans a ROWS x COLS key matrix and debounces it one whole frame at a time.
//   Each newly pressed key is reported as an encoded key code over a
//   valid/ready handshake.
//
//   A frame visits every column once. Each column stays active for SETTLE
//   cycles, and its rows are sampled in the last cycle of that dwell. When the
//   last column has been sampled, the completed raw matrix is compared with the
//   previous frame. After DEBOUNCE identical frames in a row, the raw matrix is
//   committed as the new stable matrix.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   row_in     row lines (1 = key closed on the active column), already synchronised
//   col_out    one-hot column strobe
//   key_code   code of the reported key, col*ROWS + row
//   key_valid  key_code holds an unconsumed press event
//   key_ready  consumer accepts key_code when key_valid && key_ready
//   pressed    any key down in the stable matrix
//   multi      two or more keys down in the stable matrix
//   overrun    one-cycle pulse: a press event was dropped while key_valid was pending
module keypad_scan_ctrl #(
  parameter  int ROWS     = 4,
  parameter  int COLS     = 4,
  parameter  int SETTLE   = 16,
  parameter  int DEBOUNCE = 3,
  localparam int KEY_W    = $clog2(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROWS-1:0]  row_in,
  output logic [COLS-1:0]  col_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             pressed,
  output logic             multi,
  output logic             overrun
);

  localparam int N  = ROWS * COLS;
  localparam int DW = $clog2(SETTLE);
  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(DEBOUNCE + 1);

  logic [DW-1:0]    dwell_reg;
  logic [CW-1:0]    col_idx_reg;
  logic [COLS-1:0]  col_reg;
  logic [N-1:0]     raw_reg;
  logic [N-1:0]     prev_reg;
  logic [N-1:0]     stable_reg;
  logic [AW-1:0]    agree_reg;
  logic [KEY_W-1:0] key_code_reg;
  logic             key_valid_reg;
  logic             pressed_reg;
  logic             multi_reg;
  logic             overrun_reg;

  logic             sample;
  logic             frame_end;
  logic [N-1:0]     raw_next;
  logic [AW-1:0]    agree_next;
  logic             commit;
  logic [N-1:0]     rise;
  logic [KEY_W-1:0] event_code;
  logic             key_event;
  logic             multi_next;

  assign sample    = (dwell_reg == DW'(SETTLE - 1));
  assign frame_end = sample && (col_idx_reg == CW'(COLS - 1));

  // raw_next is the raw matrix including this cycle's row sample. The
  // frame-end compare must see the last column, so it uses raw_next rather
  // than raw_reg.
  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_raw
      assign raw_next[gi*ROWS +: ROWS] =
        (sample && (col_idx_reg == CW'(gi))) ? row_in : raw_reg[gi*ROWS +: ROWS];
    end
  endgenerate

  always_comb begin
    agree_next = agree_reg;
    if (raw_next != prev_reg) begin
      agree_next = AW'(1);
    end else if (agree_reg != AW'(DEBOUNCE)) begin
      agree_next = agree_reg + AW'(1);
    end
  end

  assign commit    = frame_end && (agree_next == AW'(DEBOUNCE)) && (raw_next != stable_reg);
  assign rise      = raw_next & ~stable_reg;
  assign key_event = commit && (|rise);
  // Clearing the lowest set bit leaves something behind only if two or more
  // bits are set.
  assign multi_next = |(raw_next & (raw_next - N'(1)));

  // The lowest rising index wins. The flat bit index already equals
  // col*ROWS + row, and it always fits in KEY_W bits.
  always_comb begin
    event_code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rise[i]) event_code = KEY_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_reg     <= '0;
      col_idx_reg   <= '0;
      col_reg       <= COLS'(1);
      raw_reg       <= '0;
      prev_reg      <= '0;
      stable_reg    <= '0;
      agree_reg     <= '0;
      key_code_reg  <= '0;
      key_valid_reg <= 1'b0;
      pressed_reg   <= 1'b0;
      multi_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      raw_reg     <= raw_next;
      overrun_reg <= 1'b0;

      if (sample) begin
        dwell_reg <= '0;
        col_reg   <= {col_reg[COLS-2:0], col_reg[COLS-1]};
        if (col_idx_reg == CW'(COLS - 1)) col_idx_reg <= '0;
        else                              col_idx_reg <= col_idx_reg + CW'(1);
      end else begin
        dwell_reg <= dwell_reg + DW'(1);
      end

      if (frame_end) begin
        prev_reg  <= raw_next;
        agree_reg <= agree_next;
      end

      if (commit) begin
        stable_reg  <= raw_next;
        pressed_reg <= |raw_next;
        multi_reg   <= multi_next;
      end

      // A new event can take the slot when it is empty or is being drained
      // this cycle. Otherwise the event is dropped and the drop is flagged.
      if (key_event && (!key_valid_reg || key_ready)) begin
        key_code_reg  <= event_code;
        key_valid_reg <= 1'b1;
      end else if (key_event) begin
        overrun_reg <= 1'b1;
      end else if (key_valid_reg && key_ready) begin
        key_valid_reg <= 1'b0;
      end
    end
  end

  assign col_out   = col_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign pressed   = pressed_reg;
  assign multi     = multi_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with default parameters (4x4, SETTLE=16,
// DEBOUNCE=3, 64-cycle frame). A keypad model turns the set of held keys into
// row_in for the active column. Expected press events are queued when keys are
// pressed. They are popped and compared whenever the DUT hands an event over.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       pressed;
  logic       multi;
  logic       overrun;

  logic [15:0] keys;
  int          cyc;
  int          checks;
  int          errors;
  int          ovr_cnt;
  int          exp_q[$];

  always #5 clk = ~clk;

  keypad_scan_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .pressed   (pressed),
    .multi     (multi),
    .overrun   (overrun)
  );

  // Keypad model: key c*4+r closes row r while column c is driven.
  always_comb begin
    row_in = '0;
    for (int c = 0; c < 4; c++) begin
      if (col_out[c]) begin
        for (int r = 0; r < 4; r++) row_in[r] = row_in[r] | keys[c*4+r];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock. An accept happens at the coming edge when
  // key_valid && key_ready, so the event is scored just before the edge.
  // Outputs are sampled 1 time unit after the edge.
  task automatic step();
    if (key_valid && key_ready) begin
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL event_unexpected: observed code=%0d expected no event (cyc %0d)", key_code, cyc);
      end
      if (exp_q.size() != 0) chk("event_code", 32'(key_code), 32'(exp_q.pop_front()));
      $display("event accepted: code=%0d cyc=%0d", key_code, cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (overrun) ovr_cnt++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ovr_cnt   = 0;
    cyc       = 0;
    keys      = '0;
    key_ready = 1'b1;
    rst       = 1'b1;
    #1;

    // 1. Reset state and the column scan over one frame.
    do_reset();
    chk("rst_col_out", 32'(col_out), 1);
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_key_code", 32'(key_code), 0);
    chk("rst_pressed", 32'(pressed), 0);
    chk("rst_multi", 32'(multi), 0);
    chk("rst_overrun", 32'(overrun), 0);
    for (int i = 0; i < 64; i++) begin
      step();
      chk("scan_col_out", 32'(col_out), 32'(1 << ((cyc / 16) % 4)));
      chk("scan_idle", 32'({key_valid, pressed, multi, overrun}), 0);
    end
    $display("scan frame complete cyc=%0d", cyc);

    // 2. Clean press of key 6, held across several more frames.
    do_reset();
    keys = 16'(1 << 6);
    exp_q.push_back(6);
    run_to(191);
    chk("press_early_valid", 32'(key_valid), 0);
    step();
    chk("press_valid", 32'(key_valid), 1);
    chk("press_code", 32'(key_code), 6);
    chk("press_pressed", 32'(pressed), 1);
    chk("press_multi", 32'(multi), 0);
    step();
    chk("press_valid_drop", 32'(key_valid), 0);
    run_to(448);
    chk("hold_pressed", 32'(pressed), 1);
    chk("hold_no_repeat", exp_q.size(), 0);

    // 3. Bounce: present, absent, then present for three frames.
    do_reset();
    keys = 16'(1 << 6);
    run_to(64);
    keys = '0;
    run_to(128);
    keys = 16'(1 << 6);
    exp_q.push_back(6);
    run_to(319);
    chk("bounce_early_valid", 32'(key_valid), 0);
    step();
    chk("bounce_valid", 32'(key_valid), 1);
    chk("bounce_code", 32'(key_code), 6);
    keys = '0;
    run_to(512);
    chk("bounce_release", 32'(pressed), 0);
    keys = 16'(1 << 5);
    run_to(640);
    keys = '0;
    run_to(832);
    chk("short_press_pressed", 32'(pressed), 0);
    chk("short_press_no_event", exp_q.size(), 0);

    // 4. Two keys committed together: the lower code wins.
    do_reset();
    keys = 16'((1 << 9) | (1 << 4));
    exp_q.push_back(4);
    run_to(192);
    chk("multi_valid", 32'(key_valid), 1);
    chk("multi_code", 32'(key_code), 4);
    chk("multi_flag", 32'(multi), 1);
    chk("multi_pressed", 32'(pressed), 1);
    chk("multi_overrun", 32'(overrun), 0);
    keys = 16'(1 << 9);
    run_to(383);
    chk("multi_before_commit", 32'(multi), 1);
    step();
    chk("multi_cleared", 32'(multi), 0);
    chk("multi_still_pressed", 32'(pressed), 1);
    run_to(448);
    chk("multi_no_event", exp_q.size(), 0);
    chk("multi_overrun_count", ovr_cnt, 0);

    // 5. Backpressure: the second event is dropped and overrun pulses.
    do_reset();
    key_ready = 1'b0;
    keys = 16'(1 << 1);
    exp_q.push_back(1);
    run_to(192);
    chk("bp_valid", 32'(key_valid), 1);
    chk("bp_code", 32'(key_code), 1);
    keys = 16'(1 << 14);
    run_to(383);
    chk("bp_overrun_before", 32'(overrun), 0);
    step();
    chk("bp_overrun_pulse", 32'(overrun), 1);
    chk("bp_code_held", 32'(key_code), 1);
    chk("bp_valid_held", 32'(key_valid), 1);
    step();
    chk("bp_overrun_end", 32'(overrun), 0);
    chk("bp_code_still", 32'(key_code), 1);
    key_ready = 1'b1;
    step();
    chk("bp_valid_cleared", 32'(key_valid), 0);
    run_to(512);
    chk("bp_code14_lost", exp_q.size(), 0);
    chk("bp_overrun_count", ovr_cnt, 1);

    // 6. Reset mid-column while an event is pending.
    do_reset();
    key_ready = 1'b0;
    keys = 16'(1 << 6);
    run_to(192);
    chk("mid_valid_before", 32'(key_valid), 1);
    run_to(232);
    chk("mid_col2", 32'(col_out), 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    chk("mid_rst_valid", 32'(key_valid), 0);
    chk("mid_rst_col", 32'(col_out), 1);
    chk("mid_rst_pressed", 32'(pressed), 0);
    key_ready = 1'b1;
    exp_q.push_back(6);
    run_to(191);
    chk("mid_redebounce_early", 32'(key_valid), 0);
    step();
    chk("mid_redebounce_valid", 32'(key_valid), 1);
    chk("mid_redebounce_code", 32'(key_code), 6);
    step();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
